// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// LSU states, error causes and load/store legality check.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_RESP
   } lsu_state_e;

   typedef enum logic [1:0] {
      LSU_CAUSE_NONE,
      LSU_CAUSE_MISALIGN,
      LSU_CAUSE_FUNCT3,
      LSU_CAUSE_TIMEOUT
   } lsu_cause_e;

   // Illegal funct3 takes precedence over misalignment.
   function automatic lsu_cause_e lsu_check(
      input logic       we,
      input logic [2:0] f3,
      input logic [1:0] a
   );
      lsu_cause_e c;
      c = LSU_CAUSE_NONE;
      if (we) begin
         if (f3 > F3_SW)
            c = LSU_CAUSE_FUNCT3;
         else if (f3 == F3_SH && a[0])
            c = LSU_CAUSE_MISALIGN;
         else if (f3 == F3_SW && a != 2'b00)
            c = LSU_CAUSE_MISALIGN;
      end else begin
         if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
            c = LSU_CAUSE_FUNCT3;
         else if ((f3 == F3_LH || f3 == F3_LHU) && a[0])
            c = LSU_CAUSE_MISALIGN;
         else if (f3 == F3_LW && a != 2'b00)
            c = LSU_CAUSE_MISALIGN;
      end
      return c;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables,
// store-data replication and load extraction.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] st_data,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] sh;

   assign sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      be      = 4'b1111;
      st_data = wdata;
      case (funct3[1:0])
         2'b00: begin
            be      = 4'b0001 << addr_lo;
            st_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            be      = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            st_data = wdata;
         end
      endcase
   end

   always_comb begin
      ld_data = rdata;
      case (funct3)
         F3_LB:   ld_data = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   ld_data = {{16{sh[15]}}, sh[15:0]};
         F3_LBU:  ld_data = {24'd0, sh[7:0]};
         F3_LHU:  ld_data = {16'd0, sh[15:0]};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: request latch, bus handshake
// FSM with timeout, and single-cycle response generation.
module lsu_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [2:0]      req_funct3_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   input  logic [4:0]      req_rd_addr_i,
   output logic            mem_req_o,
   input  logic            mem_gnt_i,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [3:0]      mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            rsp_valid_o,
   output logic            rsp_rd_we_o,
   output logic [4:0]      rsp_rd_addr_o,
   output logic [XLEN-1:0] rsp_rd_data_o,
   output logic            rsp_err_o,
   output logic [1:0]      rsp_cause_o,
   output logic            busy_o
);

   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e      state_q;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [4:0]      rd_q;
   logic [CW-1:0]   cnt_q;
   logic            mem_req_q;
   lsu_cause_e      cause_q;
   lsu_cause_e      chk_cause;

   logic [3:0]      be;
   logic [XLEN-1:0] st_data;
   logic [XLEN-1:0] ld_data;

   assign chk_cause = lsu_check(req_we_i, req_funct3_i, req_addr_i[1:0]);

   lsu_align u_align (
      .funct3  (f3_q),
      .addr_lo (addr_q[1:0]),
      .wdata   (wdata_q),
      .rdata   (mem_rdata_i),
      .be      (be),
      .st_data (st_data),
      .ld_data (ld_data)
   );

   assign req_ready_o = (state_q == LSU_IDLE);
   assign busy_o      = (state_q != LSU_IDLE);
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_req_q & we_q;
   assign mem_addr_o  = mem_req_q ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_be_o    = mem_req_q ? be : 4'b0000;
   assign mem_wdata_o = mem_req_q ? st_data : '0;
   assign rsp_cause_o = cause_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= LSU_IDLE;
         we_q          <= 1'b0;
         f3_q          <= 3'b000;
         addr_q        <= '0;
         wdata_q       <= '0;
         rd_q          <= 5'd0;
         cnt_q         <= '0;
         mem_req_q     <= 1'b0;
         cause_q       <= LSU_CAUSE_NONE;
         rsp_valid_o   <= 1'b0;
         rsp_rd_we_o   <= 1'b0;
         rsp_rd_addr_o <= 5'd0;
         rsp_rd_data_o <= '0;
         rsp_err_o     <= 1'b0;
      end else begin
         unique case (state_q)
            LSU_IDLE: begin
               if (req_valid_i) begin
                  we_q          <= req_we_i;
                  f3_q          <= req_funct3_i;
                  addr_q        <= req_addr_i;
                  wdata_q       <= req_wdata_i;
                  rd_q          <= req_rd_addr_i;
                  rsp_rd_addr_o <= req_rd_addr_i;
                  if (chk_cause == LSU_CAUSE_NONE) begin
                     state_q   <= LSU_REQ;
                     mem_req_q <= 1'b1;
                     cnt_q     <= '0;
                  end else begin
                     state_q       <= LSU_RESP;
                     rsp_valid_o   <= 1'b1;
                     rsp_err_o     <= 1'b1;
                     cause_q       <= chk_cause;
                     rsp_rd_we_o   <= 1'b0;
                     rsp_rd_data_o <= '0;
                  end
               end
            end
            LSU_REQ: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q       <= LSU_RESP;
                  mem_req_q     <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  cause_q       <= LSU_CAUSE_TIMEOUT;
                  rsp_rd_we_o   <= 1'b0;
                  rsp_rd_data_o <= '0;
               end else if (mem_gnt_i) begin
                  state_q   <= LSU_WAIT;
                  mem_req_q <= 1'b0;
               end
            end
            LSU_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // A response in the final cycle still wins.
               if (mem_rvalid_i) begin
                  state_q       <= LSU_RESP;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b0;
                  cause_q       <= LSU_CAUSE_NONE;
                  rsp_rd_we_o   <= ~we_q & (rd_q != 5'd0);
                  rsp_rd_data_o <= we_q ? '0 : ld_data;
               end else if (cnt_q == CNT_LAST) begin
                  state_q       <= LSU_RESP;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  cause_q       <= LSU_CAUSE_TIMEOUT;
                  rsp_rd_we_o   <= 1'b0;
                  rsp_rd_data_o <= '0;
               end
            end
            LSU_RESP: begin
               state_q       <= LSU_IDLE;
               rsp_valid_o   <= 1'b0;
               rsp_err_o     <= 1'b0;
               cause_q       <= LSU_CAUSE_NONE;
               rsp_rd_we_o   <= 1'b0;
               rsp_rd_data_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl using a response scoreboard.
module tb_lsu_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_f3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rsp_valid;
   logic        rsp_rd_we;
   logic [4:0]  rsp_rd_addr;
   logic [31:0] rsp_rd_data;
   logic        rsp_err;
   logic [1:0]  rsp_cause;
   logic        busy;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct packed {
      logic        err;
      logic [1:0]  cause;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] data;
   } rsp_t;

   rsp_t sb[$];

   always #5 clk = ~clk;

   lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_we_i      (req_we),
      .req_funct3_i  (req_f3),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .req_rd_addr_i (req_rd),
      .mem_req_o     (mem_req),
      .mem_gnt_i     (mem_gnt),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_be_o      (mem_be),
      .mem_wdata_o   (mem_wdata),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_rd_we_o   (rsp_rd_we),
      .rsp_rd_addr_o (rsp_rd_addr),
      .rsp_rd_data_o (rsp_rd_data),
      .rsp_err_o     (rsp_err),
      .rsp_cause_o   (rsp_cause),
      .busy_o        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_cause", {30'd0, rsp_cause}, {30'd0, e.cause});
            chk("rsp_rd_we", {31'd0, rsp_rd_we}, {31'd0, e.rd_we});
            chk("rsp_rd", {27'd0, rsp_rd_addr}, {27'd0, e.rd});
            chk("rsp_data", rsp_rd_data, e.data);
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd);
      @(negedge clk);
      chk("ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_f3    = f3;
      req_addr  = a;
      req_wdata = wd;
      req_rd    = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic grant();
      @(negedge clk);
      mem_gnt = 1'b1;
      @(posedge clk);
      #1 mem_gnt = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_memreq", {31'd0, mem_req}, 32'd0);
      chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      rst = 1'b0;

      // SW then LW
      sb.push_back('{1'b0, 2'd0, 1'b0, 5'd1, 32'd0});
      issue(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 5'd1);
      @(negedge clk);
      chk("sw_req", {31'd0, mem_req}, 32'd1);
      chk("sw_we", {31'd0, mem_we}, 32'd1);
      chk("sw_be", {28'd0, mem_be}, 32'hF);
      chk("sw_addr", mem_addr, 32'h100);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_busy", {31'd0, busy}, 32'd1);
      grant();
      respond(32'h0);
      idle_cycles(2);

      sb.push_back('{1'b0, 2'd0, 1'b1, 5'd5, 32'hDEADBEEF});
      issue(1'b0, F3_LW, 32'h100, 32'h0, 5'd5);
      @(negedge clk);
      chk("lw_addr", mem_addr, 32'h100);
      chk("lw_we", {31'd0, mem_we}, 32'd0);
      grant();
      respond(32'hDEADBEEF);
      @(negedge clk);
      chk("lw_t3", {31'd0, rsp_valid}, 32'd1);
      idle_cycles(2);

      // Byte lanes
      sb.push_back('{1'b0, 2'd0, 1'b1, 5'd6, 32'hFFFFFF80});
      issue(1'b0, F3_LB, 32'h103, 32'h0, 5'd6);
      @(negedge clk);
      chk("lb_addr", mem_addr, 32'h100);
      grant();
      respond(32'h80FF1234);
      idle_cycles(2);

      sb.push_back('{1'b0, 2'd0, 1'b1, 5'd6, 32'h00000080});
      issue(1'b0, F3_LBU, 32'h103, 32'h0, 5'd6);
      grant();
      respond(32'h80FF1234);
      idle_cycles(2);

      // rd=0 load writes nothing back
      sb.push_back('{1'b0, 2'd0, 1'b0, 5'd0, 32'hFFFF80FF});
      issue(1'b0, F3_LH, 32'h102, 32'h0, 5'd0);
      grant();
      respond(32'h80FF1234);
      idle_cycles(2);

      // Store replication
      sb.push_back('{1'b0, 2'd0, 1'b0, 5'd2, 32'd0});
      issue(1'b1, F3_SH, 32'h102, 32'h0000ABCD, 5'd2);
      @(negedge clk);
      chk("sh_be", {28'd0, mem_be}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'hABCDABCD);
      chk("sh_addr", mem_addr, 32'h100);
      grant();
      respond(32'h0);
      idle_cycles(2);

      sb.push_back('{1'b0, 2'd0, 1'b0, 5'd2, 32'd0});
      issue(1'b1, F3_SB, 32'h101, 32'h000000A5, 5'd2);
      @(negedge clk);
      chk("sb_be", {28'd0, mem_be}, 32'h2);
      chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
      grant();
      respond(32'h0);
      idle_cycles(2);

      // Misaligned and illegal funct3
      sb.push_back('{1'b1, 2'd1, 1'b0, 5'd3, 32'd0});
      issue(1'b0, F3_LW, 32'h101, 32'h0, 5'd3);
      @(negedge clk);
      chk("mis_rspv", {31'd0, rsp_valid}, 32'd1);
      chk("mis_memreq", {31'd0, mem_req}, 32'd0);
      idle_cycles(2);

      sb.push_back('{1'b1, 2'd2, 1'b0, 5'd3, 32'd0});
      issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd3);
      @(negedge clk);
      chk("f3_memreq", {31'd0, mem_req}, 32'd0);
      idle_cycles(2);

      // Grant stall then timeout
      sb.push_back('{1'b1, 2'd3, 1'b0, 5'd4, 32'd0});
      issue(1'b1, F3_SW, 32'h200, 32'h12345678, 5'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req", {31'd0, mem_req}, 32'd1);
         chk("stall_addr", mem_addr, 32'h200);
         chk("stall_wd", mem_wdata, 32'h12345678);
         chk("stall_be", {28'd0, mem_be}, 32'hF);
      end
      grant();
      @(negedge clk);
      chk("wait_noreq", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk("to_early", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("to_fire", {31'd0, rsp_valid}, 32'd1);
      idle_cycles(2);
      respond(32'hCAFEF00D);
      @(negedge clk);
      chk("late_rv_busy", {31'd0, busy}, 32'd0);
      idle_cycles(2);

      // Reset while waiting for data
      issue(1'b0, F3_LW, 32'h300, 32'h0, 5'd9);
      grant();
      @(negedge clk);
      chk("rm_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rm_memreq", {31'd0, mem_req}, 32'd0);
      chk("rm_busy0", {31'd0, busy}, 32'd0);
      chk("rm_ready", {31'd0, req_ready}, 32'd1);
      chk("rm_rspv", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      respond(32'h11111111);
      idle_cycles(3);

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles from mem_req_o rise to mem_rvalid_i before a bus-error response.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 req_valid_i  in  1  execute stage presents a load/store.
REQ-006 req_ready_o  out  1  lsu_ctrl accepts request this cycle.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_funct3_i  in  3  F3_LB/LH/LW/LBU/LHU or F3_SB/SH/SW.
REQ-009 req_addr_i  in  XLEN  byte address (rs1 + imm).
REQ-010 req_wdata_i  in  XLEN  store data (rs2).
REQ-011 req_rd_addr_i  in  5  load destination register.
REQ-012 mem_req_o / mem_gnt_i  out/in  1/1  memory request and grant.
REQ-013 mem_we_o  out  1; mem_addr_o  out  XLEN, word-aligned; mem_be_o  out  4; mem_wdata_o  out  XLEN.
REQ-014 mem_rvalid_i  in  1; mem_rdata_i  in  XLEN: response/ack, for loads and stores.
REQ-015 rsp_valid_o  out  1; rsp_rd_we_o  out  1; rsp_rd_addr_o  out  5; rsp_rd_data_o  out  XLEN.
REQ-016 rsp_err_o  out  1; rsp_cause_o  out  2 (0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout).
REQ-017 busy_o  out  1  high whenever state != IDLE; the pipeline stalls on it.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-019 IDLE: on req_valid_i, latch we/funct3/addr/wdata/rd_addr; go to REQ if legal, else to RESP with error.
REQ-020 Legality: LH/LHU/SH need addr[0]=0 and LW/SW need addr[1:0]=0, else cause 1; load funct3 011/110/111 or store funct3 >010 is cause 2. An illegal request issues no memory access.
REQ-021 REQ: mem_req_o=1 with stable addr/we/be/wdata until the mem_gnt_i cycle, then go to WAIT.
REQ-022 WAIT: on mem_rvalid_i, capture mem_rdata_i and go to RESP.
REQ-023 Timeout counter: clears on entry to REQ and counts every cycle in REQ and WAIT. At TIMEOUT_CYCLES, go to RESP with cause 3 and drop mem_req_o.
REQ-024 RESP: rsp_valid_o=1 for exactly one cycle, then go to IDLE. Minimum load latency with same-cycle grant: accept T0, mem_req T1, rvalid T2, rsp T3.
REQ-025 mem_addr_o = {addr[XLEN-1:2], 2'b00}.
REQ-026 Byte enables: SB = 1 << addr[1:0]; SH = 4'b0011 (addr[1]=0) or 4'b1100; SW = 4'b1111.
REQ-027 Store data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves.
REQ-028 Load extract: shift rdata right by 8*addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through unchanged.
REQ-029 rsp_rd_we_o = 1 only for an error-free load with rd_addr != 0. Stores and errors: rd_we=0 and rd_data=0.
REQ-030 mem_rvalid_i outside WAIT (late response after timeout) is ignored; mem_gnt_i outside REQ is ignored.
REQ-031 req_valid_i during REQ/WAIT/RESP is not accepted; the request must be held until req_ready_o.

Reset
REQ-032 On rst_i: state=IDLE; timeout counter=0; all outputs 0 except req_ready_o=1.
REQ-033 Reset mid-operation aborts immediately: mem_req_o drops next cycle and no rsp_valid_o is produced for the aborted request.

Structure
REQ-034 riscv_pkg gains lsu_state_e, lsu_cause_e, and F3_SB/F3_SH/F3_SW if absent; existing F3_L* constants are reused.
REQ-035 A combinational sub-module lsu_align contains the byte-enable, store-replication and load-extract logic; lsu_ctrl holds the FSM, latches and counter.

Verification
REQ-036 Test 1 (store then load): SW addr 0x100 wdata 0xDEADBEEF -> be=1111, addr 0x100, rsp rd_we=0. Then LW addr 0x100 with rdata 0xDEADBEEF -> rd_data 0xDEADBEEF, rsp at T3.
REQ-037 Test 2 (byte lanes): LB addr 0x103 with rdata 0x80FF1234 -> rd_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 Test 3 (store replication): SH addr 0x102 wdata 0x0000ABCD -> be=1100, mem_wdata 0xABCDABCD.
REQ-039 Test 4 (misaligned): LW addr 0x101 -> no mem_req_o, rsp_err=1, cause=1, rd_we=0.
REQ-040 Test 5 (grant stall and timeout): hold mem_gnt_i low 5 cycles -> mem_req_o held with stable fields. With TIMEOUT_CYCLES=8 and no rvalid -> cause=3 after 8 cycles, and a later rvalid is ignored.
REQ-041 Test 6 (reset mid-op): assert rst_i in WAIT -> next cycle IDLE, mem_req_o=0, no rsp_valid_o.
